// File: rtl/ordered_system_bus.sv
// ordered_system_bus: single-leader, multi-follower memory-mapped interconnect.
// Requests are decoupled through a FIFO (leader_ready = not full), dispatched
// to the follower chosen by the top address tag, and read responses are
// returned to the leader strictly in issue order.
// Optional feature macro: ORDERED_BUS_DECODE_ERROR_EN -- reads to unmapped
// tags return a zero-data error response instead of being silently dropped.
module ordered_system_bus #(
  parameter int Followers       = 4,
  parameter int AddrWidth       = 32,
  parameter int DataWidth       = 32,
  parameter int TagWidth        = 4,
  parameter int DepthBits       = 3,
  parameter int OutstandingBits = 3
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [AddrWidth-1:0]              leader_addr,
  input  logic                              leader_read_req,
  input  logic                              leader_write_req,
  input  logic [DataWidth/8-1:0]            leader_byte_enable,
  input  logic [DataWidth-1:0]              leader_write_data,
  output logic                              leader_ready,
  output logic [DataWidth-1:0]              leader_read_data,
  output logic                              leader_read_data_valid,
  output logic                              leader_error,
  output logic [Followers*AddrWidth-1:0]    follower_addr,
  output logic [Followers-1:0]              follower_read_req,
  output logic [Followers-1:0]              follower_write_req,
  output logic [Followers*DataWidth/8-1:0]  follower_byte_enable,
  output logic [Followers*DataWidth-1:0]    follower_write_data,
  input  logic [Followers*DataWidth-1:0]    follower_read_data,
  input  logic [Followers-1:0]              follower_read_data_valid
);

  localparam int BeWidth  = DataWidth / 8;
  localparam int ReqDepth = 2 ** DepthBits;
  localparam int OrdDepth = 2 ** OutstandingBits;
  localparam int IdxWidth = (Followers > 1) ? $clog2(Followers) : 1;
  localparam logic [TagWidth:0]        FollowerCount = (TagWidth+1)'(Followers);
  localparam logic [AddrWidth-1:0]     TagMask = {{TagWidth{1'b1}}, {(AddrWidth-TagWidth){1'b0}}};
  localparam logic [DepthBits:0]       ReqOne = (DepthBits+1)'(1);
  localparam logic [DepthBits:0]       ReqFull = (DepthBits+1)'(ReqDepth);
  localparam logic [OutstandingBits:0] OrdOne = (OutstandingBits+1)'(1);
  localparam logic [OutstandingBits:0] OrdFull = (OutstandingBits+1)'(OrdDepth);

`ifdef ORDERED_BUS_DECODE_ERROR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  // ---------------- request FIFO ----------------
  logic [AddrWidth-1:0]   rq_addr_mem  [ReqDepth];
  logic                   rq_write_mem [ReqDepth];
  logic [BeWidth-1:0]     rq_be_mem    [ReqDepth];
  logic [DataWidth-1:0]   rq_data_mem  [ReqDepth];
  logic [DepthBits-1:0]   rq_wptr, rq_rptr;
  logic [DepthBits:0]     rq_count, rq_count_next;
  logic                   rq_full, rq_empty;
  logic                   accept, dispatch;

  logic [AddrWidth-1:0]   head_addr;
  logic                   head_write;
  logic [BeWidth-1:0]     head_be;
  logic [DataWidth-1:0]   head_data;
  logic [TagWidth-1:0]    head_tag;
  logic                   head_mapped;
  logic [IdxWidth-1:0]    head_idx;
  logic                   issue_read;

  // ---------------- order FIFO ----------------
  logic [IdxWidth-1:0]        ord_idx_mem [OrdDepth];
  logic                       ord_err_mem [OrdDepth];
  logic [OutstandingBits-1:0] ord_wptr, ord_rptr;
  logic [OutstandingBits:0]   ord_count;
  logic                       ord_full, ord_empty, ord_push, ord_pop;
  logic [IdxWidth-1:0]        ord_head_idx;
  logic                       ord_head_err;
  logic                       err_ret;

  // ---------------- per-follower response tracking ----------------
  logic [DataWidth-1:0]       rsp_mem [Followers][OrdDepth];
  logic [OutstandingBits-1:0] rsp_wptr [Followers];
  logic [OutstandingBits-1:0] rsp_rptr [Followers];
  logic [OutstandingBits:0]   rsp_count [Followers];
  logic [OutstandingBits:0]   outstanding [Followers];
  logic [Followers-1:0]       capture, bypass, rsp_push, rsp_pop, issue_sel;
  logic [DataWidth-1:0]       ret_data;

  assign leader_ready = ~rq_full;
  assign rq_empty     = (rq_count == '0);
  assign accept       = (leader_read_req | leader_write_req) & ~rq_full;

  assign head_addr   = rq_addr_mem[rq_rptr];
  assign head_write  = rq_write_mem[rq_rptr];
  assign head_be     = rq_be_mem[rq_rptr];
  assign head_data   = rq_data_mem[rq_rptr];
  assign head_tag    = head_addr[AddrWidth-1 -: TagWidth];
  assign head_mapped = ({1'b0, head_tag} < FollowerCount);
  assign head_idx    = head_tag[IdxWidth-1:0];

  // A read at the head blocks everything behind it while the order FIFO is full.
  assign dispatch   = ~rq_empty & (head_write | ~ord_full);
  assign issue_read = dispatch & ~head_write & head_mapped;
  assign ord_push   = dispatch & ~head_write & (head_mapped | ErrEn);

  assign ord_empty    = (ord_count == '0);
  assign ord_full     = (ord_count == OrdFull);
  assign ord_head_idx = ord_idx_mem[ord_rptr];
  assign ord_head_err = ord_err_mem[ord_rptr];
  assign err_ret      = ErrEn & ~ord_empty & ord_head_err;
  assign ord_pop      = (|rsp_pop) | (|bypass) | err_ret;

  // Next occupancy of the request FIFO; full is registered from it.
  always_comb begin
    rq_count_next = rq_count;
    if (accept && !dispatch)
      rq_count_next = rq_count + ReqOne;
    else if (!accept && dispatch)
      rq_count_next = rq_count - ReqOne;
  end

  // Request FIFO storage; read_req with write_req is treated as a write.
  always_ff @(posedge clk) begin
    if (accept) begin
      rq_addr_mem[rq_wptr]  <= leader_addr;
      rq_write_mem[rq_wptr] <= leader_write_req;
      rq_be_mem[rq_wptr]    <= leader_byte_enable;
      rq_data_mem[rq_wptr]  <= leader_write_data;
    end
  end

  // Request FIFO pointers, count and registered full flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rq_wptr  <= '0;
      rq_rptr  <= '0;
      rq_count <= '0;
      rq_full  <= 1'b0;
    end else begin
      if (accept)
        rq_wptr <= rq_wptr + 1'b1;
      if (dispatch)
        rq_rptr <= rq_rptr + 1'b1;
      rq_count <= rq_count_next;
      rq_full  <= (rq_count_next == ReqFull);
    end
  end

  // Order FIFO storage: follower index plus decode-error marker per read.
  always_ff @(posedge clk) begin
    if (ord_push) begin
      ord_idx_mem[ord_wptr] <= head_idx;
      ord_err_mem[ord_wptr] <= ~head_mapped;
    end
  end

  // Order FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ord_wptr  <= '0;
      ord_rptr  <= '0;
      ord_count <= '0;
    end else begin
      if (ord_push)
        ord_wptr <= ord_wptr + 1'b1;
      if (ord_pop)
        ord_rptr <= ord_rptr + 1'b1;
      case ({ord_push, ord_pop})
        2'b10:   ord_count <= ord_count + OrdOne;
        2'b01:   ord_count <= ord_count - OrdOne;
        default: ord_count <= ord_count;
      endcase
    end
  end

  // Capture, return selection and fall-through bypass for the head follower.
  always_comb begin
    capture   = '0;
    bypass    = '0;
    rsp_push  = '0;
    rsp_pop   = '0;
    issue_sel = '0;
    ret_data  = '0;
    for (int i = 0; i < Followers; i++) begin
      capture[i]   = follower_read_data_valid[i] && (outstanding[i] != '0);
      issue_sel[i] = issue_read && (head_idx == IdxWidth'(i));
      if (!ord_empty && !ord_head_err && (ord_head_idx == IdxWidth'(i))) begin
        if (rsp_count[i] != '0) begin
          rsp_pop[i] = 1'b1;
          ret_data   = rsp_mem[i][rsp_rptr[i]];
        end else if (capture[i]) begin
          bypass[i] = 1'b1;
          ret_data  = follower_read_data[i*DataWidth +: DataWidth];
        end
      end
      rsp_push[i] = capture[i] && !bypass[i];
    end
  end

  // Per-follower response FIFO storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < Followers; i++) begin
      if (rsp_push[i])
        rsp_mem[i][rsp_wptr[i]] <= follower_read_data[i*DataWidth +: DataWidth];
    end
  end

  // Per-follower response pointers and outstanding-read counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Followers; i++) begin
        rsp_wptr[i]    <= '0;
        rsp_rptr[i]    <= '0;
        rsp_count[i]   <= '0;
        outstanding[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Followers; i++) begin
        if (rsp_push[i])
          rsp_wptr[i] <= rsp_wptr[i] + 1'b1;
        if (rsp_pop[i])
          rsp_rptr[i] <= rsp_rptr[i] + 1'b1;
        case ({rsp_push[i], rsp_pop[i]})
          2'b10:   rsp_count[i] <= rsp_count[i] + OrdOne;
          2'b01:   rsp_count[i] <= rsp_count[i] - OrdOne;
          default: rsp_count[i] <= rsp_count[i];
        endcase
        case ({issue_sel[i], capture[i]})
          2'b10:   outstanding[i] <= outstanding[i] + OrdOne;
          2'b01:   outstanding[i] <= outstanding[i] - OrdOne;
          default: outstanding[i] <= outstanding[i];
        endcase
      end
    end
  end

  // Registered follower request pulses; unselected followers see all zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      follower_read_req    <= '0;
      follower_write_req   <= '0;
      follower_addr        <= '0;
      follower_byte_enable <= '0;
      follower_write_data  <= '0;
    end else begin
      follower_read_req    <= '0;
      follower_write_req   <= '0;
      follower_addr        <= '0;
      follower_byte_enable <= '0;
      follower_write_data  <= '0;
      if (dispatch && head_mapped) begin
        for (int i = 0; i < Followers; i++) begin
          if (head_idx == IdxWidth'(i)) begin
            follower_read_req[i]                        <= ~head_write;
            follower_write_req[i]                       <= head_write;
            follower_addr[i*AddrWidth +: AddrWidth]     <= head_addr & ~TagMask;
            follower_byte_enable[i*BeWidth +: BeWidth]  <= head_be;
            follower_write_data[i*DataWidth +: DataWidth] <= head_data;
          end
        end
      end
    end
  end

  // Registered in-order response to the leader, one per cycle at most.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leader_read_data       <= '0;
      leader_read_data_valid <= 1'b0;
    end else begin
      leader_read_data_valid <= ord_pop;
      leader_read_data       <= ord_pop ? ret_data : '0;
    end
  end

`ifdef ORDERED_BUS_DECODE_ERROR_EN
  // Error flag accompanies the zero-data response of an unmapped read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      leader_error <= 1'b0;
    else
      leader_error <= err_ret;
  end
`else
  assign leader_error = 1'b0;
`endif

endmodule

// File: tb/tb_ordered_system_bus.sv
// tb_ordered_system_bus: directed vector table plus hand-written sequences for
// back-pressure, spurious strobes, decode errors and reset mid-transaction.
`timescale 1ns/1ps
module tb_ordered_system_bus;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   leader_addr = '0;
  logic          leader_read_req = 1'b0;
  logic          leader_write_req = 1'b0;
  logic [3:0]    leader_byte_enable = '0;
  logic [31:0]   leader_write_data = '0;
  logic          leader_ready;
  logic [31:0]   leader_read_data;
  logic          leader_read_data_valid;
  logic          leader_error;
  logic [127:0]  follower_addr;
  logic [3:0]    follower_read_req;
  logic [3:0]    follower_write_req;
  logic [15:0]   follower_byte_enable;
  logic [127:0]  follower_write_data;
  logic [127:0]  follower_read_data = '0;
  logic [3:0]    follower_read_data_valid = '0;

  int tests_run = 0;
  int tests_failed = 0;

  ordered_system_bus #(
    .Followers(4), .AddrWidth(32), .DataWidth(32),
    .TagWidth(4), .DepthBits(3), .OutstandingBits(3)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .leader_addr(leader_addr), .leader_read_req(leader_read_req),
    .leader_write_req(leader_write_req), .leader_byte_enable(leader_byte_enable),
    .leader_write_data(leader_write_data), .leader_ready(leader_ready),
    .leader_read_data(leader_read_data), .leader_read_data_valid(leader_read_data_valid),
    .leader_error(leader_error), .follower_addr(follower_addr),
    .follower_read_req(follower_read_req), .follower_write_req(follower_write_req),
    .follower_byte_enable(follower_byte_enable), .follower_write_data(follower_write_data),
    .follower_read_data(follower_read_data), .follower_read_data_valid(follower_read_data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic         rd;
    logic         wr;
    logic [3:0]   be;
    logic [31:0]  wdata;
    logic [127:0] frdata;
    logic [3:0]   frvalid;
    logic         exp_ready;
    logic         exp_valid;
    logic [31:0]  exp_data;
    logic [3:0]   exp_rreq;
    logic [3:0]   exp_wreq;
    logic [127:0] exp_faddr;
    logic [15:0]  exp_fbe;
    logic [127:0] exp_fwdata;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mkv(input logic [31:0] addr, input logic rd, input logic wr,
                               input logic [3:0] be, input logic [31:0] wdata,
                               input logic [127:0] frdata, input logic [3:0] frvalid,
                               input logic rdy, input logic vld, input logic [31:0] dat,
                               input logic [3:0] rreq, input logic [3:0] wreq,
                               input logic [127:0] fa, input logic [15:0] fbe,
                               input logic [127:0] fwd);
    vec_t v;
    v.addr = addr; v.rd = rd; v.wr = wr; v.be = be; v.wdata = wdata;
    v.frdata = frdata; v.frvalid = frvalid;
    v.exp_ready = rdy; v.exp_valid = vld; v.exp_data = dat;
    v.exp_rreq = rreq; v.exp_wreq = wreq;
    v.exp_faddr = fa; v.exp_fbe = fbe; v.exp_fwdata = fwd;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Drives one table row for one cycle starting just after the rising edge.
  task automatic apply_stimulus(input vec_t v);
    step();
    leader_addr = v.addr;
    leader_read_req = v.rd;
    leader_write_req = v.wr;
    leader_byte_enable = v.be;
    leader_write_data = v.wdata;
    follower_read_data = v.frdata;
    follower_read_data_valid = v.frvalid;
  endtask

  task automatic check_vector(input int i, input vec_t v);
    sample();
    check_output($sformatf("vec%0d ready", i), 128'(leader_ready), 128'(v.exp_ready));
    check_output($sformatf("vec%0d rvalid", i), 128'(leader_read_data_valid), 128'(v.exp_valid));
    check_output($sformatf("vec%0d error", i), 128'(leader_error), 128'(1'b0));
    check_output($sformatf("vec%0d f_rreq", i), 128'(follower_read_req), 128'(v.exp_rreq));
    check_output($sformatf("vec%0d f_wreq", i), 128'(follower_write_req), 128'(v.exp_wreq));
    if (v.exp_valid)
      check_output($sformatf("vec%0d rdata", i), 128'(leader_read_data), 128'(v.exp_data));
    if ((v.exp_rreq | v.exp_wreq) != 4'h0) begin
      check_output($sformatf("vec%0d f_addr", i), follower_addr, v.exp_faddr);
      check_output($sformatf("vec%0d f_be", i), 128'(follower_byte_enable), 128'(v.exp_fbe));
      check_output($sformatf("vec%0d f_wdata", i), follower_write_data, v.exp_fwdata);
    end
  endtask

  task automatic idle_inputs();
    leader_addr = '0; leader_read_req = 1'b0; leader_write_req = 1'b0;
    leader_byte_enable = '0; leader_write_data = '0;
    follower_read_data = '0; follower_read_data_valid = '0;
  endtask

  task automatic issue_read(input logic [31:0] addr);
    step();
    leader_addr = addr;
    leader_read_req = 1'b1;
    step();
    leader_read_req = 1'b0;
    leader_addr = '0;
  endtask

  task automatic wait_pulse(input int f, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      sample();
      if (follower_read_req[f]) ok = 1'b1;
    end
    check_output(name, 128'(ok), 128'(1'b1));
  endtask

  task automatic respond(input int f, input logic [31:0] data);
    step();
    follower_read_data = '0;
    follower_read_data[f*32 +: 32] = data;
    follower_read_data_valid = 4'b0001 << f;
    step();
    follower_read_data = '0;
    follower_read_data_valid = '0;
  endtask

  // Back-pressure model state: per-follower pending masked addresses.
  logic [31:0] pend [4][16];
  int          ph [4];
  int          pt [4];
  int          n_disp;

  task automatic collect_pulses();
    for (int f = 0; f < 4; f++) begin
      if (follower_read_req[f]) begin
        pend[f][pt[f]] = follower_addr[f*32 +: 32];
        pt[f]++;
        n_disp++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_acc, n_resp, n_valid, n_err, n_pulse, valid_cycle;
    logic [31:0] seen_data;
    logic seen_err;

    vecs[0]  = mkv(32'h1000_0040, 1'b0, 1'b1, 4'hF, 32'hCAFE_F00D, '0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0, 4'h0, '0, 16'h0, '0);
    vecs[1]  = mkv(32'h0, 1'b0, 1'b0, 4'h0, 32'h0, '0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0, 4'h0, '0, 16'h0, '0);
    vecs[2]  = mkv(32'h0, 1'b0, 1'b0, 4'h0, 32'h0, '0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0, 4'h2,
                   128'h00000000_00000000_00000040_00000000, 16'h00F0,
                   128'h00000000_00000000_CAFEF00D_00000000);
    vecs[3]  = mkv(32'h0, 1'b0, 1'b0, 4'h0, 32'h0, '0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0, 4'h0, '0, 16'h0, '0);
    vecs[4]  = mkv(32'h2000_0010, 1'b1, 1'b0, 4'h0, 32'h0, '0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0, 4'h0, '0, 16'h0, '0);
    vecs[5]  = mkv(32'h0000_0020, 1'b1, 1'b0, 4'h0, 32'h0, '0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0, 4'h0, '0, 16'h0, '0);
    vecs[6]  = mkv(32'h0, 1'b0, 1'b0, 4'h0, 32'h0, '0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h4, 4'h0,
                   128'h00000000_00000010_00000000_00000000, 16'h0, '0);
    vecs[7]  = mkv(32'h0, 1'b0, 1'b0, 4'h0, 32'h0, '0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h1, 4'h0,
                   128'h00000000_00000000_00000000_00000020, 16'h0, '0);
    vecs[8]  = mkv(32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 128'h00000000_00000000_00000000_00000011, 4'h1,
                   1'b1, 1'b0, 32'h0, 4'h0, 4'h0, '0, 16'h0, '0);
    vecs[9]  = mkv(32'h0, 1'b0, 1'b0, 4'h0, 32'h0, '0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0, 4'h0, '0, 16'h0, '0);
    vecs[10] = mkv(32'h0, 1'b0, 1'b0, 4'h0, 32'h0, '0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0, 4'h0, '0, 16'h0, '0);
    vecs[11] = mkv(32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 128'h00000000_00000022_00000000_00000000, 4'h4,
                   1'b1, 1'b0, 32'h0, 4'h0, 4'h0, '0, 16'h0, '0);
    vecs[12] = mkv(32'h0, 1'b0, 1'b0, 4'h0, 32'h0, '0, 4'h0, 1'b1, 1'b1, 32'h22, 4'h0, 4'h0, '0, 16'h0, '0);
    vecs[13] = mkv(32'h0, 1'b0, 1'b0, 4'h0, 32'h0, '0, 4'h0, 1'b1, 1'b1, 32'h11, 4'h0, 4'h0, '0, 16'h0, '0);
    vecs[14] = mkv(32'h0, 1'b0, 1'b0, 4'h0, 32'h0, '0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0, 4'h0, '0, 16'h0, '0);

    // Reset state.
    repeat (3) @(posedge clk);
    sample();
    check_output("reset ready", 128'(leader_ready), 128'(1'b1));
    check_output("reset rvalid", 128'(leader_read_data_valid), 128'(1'b0));
    check_output("reset error", 128'(leader_error), 128'(1'b0));
    check_output("reset f_req", 128'({follower_read_req, follower_write_req}), 128'(8'h0));
    check_output("reset f_addr", follower_addr, 128'h0);
    step();
    reset_n = 1'b1;

    // Write routing and read reordering from the table.
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i]);
      check_vector(i, vecs[i]);
    end
    step();
    idle_inputs();

    // Back-pressure: hold read requests with silent followers.
    for (int f = 0; f < 4; f++) begin ph[f] = 0; pt[f] = 0; end
    n_disp = 0;
    n_acc = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      leader_read_req = 1'b1;
      leader_addr = (32'(n_acc % 4) << 28) | 32'(n_acc * 16);
      sample();
      if (leader_ready) n_acc++;
      collect_pulses();
    end
    step();
    leader_read_req = 1'b0;
    leader_addr = '0;
    sample();
    check_output("bp accepted", 128'(n_acc), 128'(16));
    check_output("bp ready low", 128'(leader_ready), 128'(1'b0));
    check_output("bp dispatched", 128'(n_disp), 128'(8));

    // Release followers in rotating order; responses must come in issue order.
    n_resp = 0;
    for (int c = 0; c < 300 && n_resp < 16; c++) begin
      int f;
      step();
      follower_read_data = '0;
      follower_read_data_valid = '0;
      f = 3 - (c % 4);
      if (ph[f] != pt[f]) begin
        follower_read_data[f*32 +: 32] = 32'hD000_0000 | pend[f][ph[f]];
        follower_read_data_valid[f] = 1'b1;
        ph[f]++;
      end
      sample();
      collect_pulses();
      if (leader_read_data_valid) begin
        check_output($sformatf("bp resp%0d", n_resp), 128'(leader_read_data),
                     128'(32'hD000_0000 | 32'(n_resp * 16)));
        n_resp++;
      end
    end
    step();
    idle_inputs();
    check_output("bp responses", 128'(n_resp), 128'(16));
    check_output("bp all dispatched", 128'(n_disp), 128'(16));
    sample();
    check_output("bp ready back", 128'(leader_ready), 128'(1'b1));

    // Spurious strobe on follower 3 with nothing outstanding.
    step();
    follower_read_data[96 +: 32] = 32'h0000_0BAD;
    follower_read_data_valid = 4'b1000;
    step();
    idle_inputs();
    n_valid = 0;
    for (int c = 0; c < 4; c++) begin
      sample();
      if (leader_read_data_valid) n_valid++;
    end
    check_output("spurious no resp", 128'(n_valid), 128'(0));
    issue_read(32'h3000_0100);
    wait_pulse(3, "spurious f3 pulse");
    check_output("spurious f3 addr", 128'(follower_addr[96 +: 32]), 128'(32'h0000_0100));
    respond(3, 32'h33);
    sample();
    check_output("spurious then valid", 128'(leader_read_data_valid), 128'(1'b1));
    check_output("spurious then data", 128'(leader_read_data), 128'(32'h33));

    // Unmapped read and write.
    step();
    leader_addr = 32'h5000_0000;
    leader_read_req = 1'b1;
    step();
    leader_read_req = 1'b0;
    leader_addr = 32'h7000_0000;
    leader_write_req = 1'b1;
    leader_write_data = 32'h1234_5678;
    leader_byte_enable = 4'hF;
    n_valid = 0; n_err = 0; n_pulse = 0; valid_cycle = -1;
    seen_data = '0; seen_err = 1'b0;
    for (int c = 1; c < 8; c++) begin
      if (c > 1) begin
        step();
        idle_inputs();
      end
      sample();
      if ((follower_read_req | follower_write_req) != 4'h0) n_pulse++;
      if (leader_error) n_err++;
      if (leader_read_data_valid) begin
        n_valid++;
        if (valid_cycle < 0) valid_cycle = c;
        seen_data = leader_read_data;
        seen_err = leader_error;
      end
    end
    check_output("unmapped no pulse", 128'(n_pulse), 128'(0));
`ifdef ORDERED_BUS_DECODE_ERROR_EN
    check_output("decode err count", 128'(n_valid), 128'(1));
    check_output("decode err cycle", 128'(valid_cycle), 128'(3));
    check_output("decode err data", 128'(seen_data), 128'(32'h0));
    check_output("decode err flag", 128'(seen_err), 128'(1'b1));
`else
    check_output("unmapped no resp", 128'(n_valid), 128'(0));
    check_output("unmapped no error", 128'(n_err), 128'(0));
`endif

    // Reset with three reads outstanding.
    issue_read(32'h0000_0004);
    issue_read(32'h1000_0008);
    issue_read(32'h2000_000C);
    repeat (4) sample();
    step();
    reset_n = 1'b0;
    follower_read_data = 128'h000000EE_000000EE_000000EE_000000EE;
    follower_read_data_valid = 4'b0001;
    sample();
    check_output("rst ready", 128'(leader_ready), 128'(1'b1));
    check_output("rst rvalid", 128'(leader_read_data_valid), 128'(1'b0));
    check_output("rst f_req", 128'({follower_read_req, follower_write_req}), 128'(8'h0));
    check_output("rst f_addr", follower_addr, 128'h0);
    step();
    follower_read_data_valid = '0;
    reset_n = 1'b1;
    step();
    follower_read_data_valid = 4'b0110;
    step();
    idle_inputs();
    n_valid = 0;
    for (int c = 0; c < 5; c++) begin
      sample();
      if (leader_read_data_valid) n_valid++;
    end
    check_output("rst no stale resp", 128'(n_valid), 128'(0));
    check_output("rst ready after", 128'(leader_ready), 128'(1'b1));
    issue_read(32'h1000_0010);
    wait_pulse(1, "rst f1 pulse");
    respond(1, 32'h44);
    sample();
    check_output("rst fresh valid", 128'(leader_read_data_valid), 128'(1'b1));
    check_output("rst fresh data", 128'(leader_read_data), 128'(32'h44));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
